// File: rtl/dat_mem_lfsr5_unit.sv
// rtl/dat_mem_lfsr5_unit.sv - 2**AW x DW data memory plus run-time-tapped Fibonacci LFSR keystream
// Optional macro MEM_WRITE_BYPASS_EN: write-first bypass when raddr==waddr during a write.
module dat_mem_lfsr5_unit #(
  parameter int AW = 8,
  parameter int DW = 8,
  parameter int LW = 5,
  parameter logic [LW-1:0] LRST = 5'h01
) (
  input  logic          clk,
  input  logic          init,
  input  logic          write_en,
  input  logic [AW-1:0] waddr,
  input  logic [AW-1:0] raddr,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] data_out,
  input  logic          lfsr_en,
  input  logic          lfsr_load,
  input  logic [LW-1:0] taps,
  input  logic [LW-1:0] start,
  output logic [LW-1:0] state
);

  // Memory contents deliberately survive init; only the LFSR is reset.
  logic [DW-1:0] mem [0:(2**AW)-1];
  logic          feedback;

  always_ff @(posedge clk) begin
    if (write_en) begin
      mem[waddr] <= data_in;
    end
  end

`ifdef MEM_WRITE_BYPASS_EN
  assign data_out = (write_en && (raddr == waddr)) ? data_in : mem[raddr];
`else
  assign data_out = mem[raddr];
`endif

  // An all-zero state is a legal lock-up point and is left uncorrected.
  assign feedback = ^(state & taps);

  always_ff @(posedge clk) begin
    if (init) begin
      state <= LRST;
    end else if (lfsr_load) begin
      state <= start;
    end else if (lfsr_en) begin
      state <= {state[LW-2:0], feedback};
    end
  end

endmodule

// File: tb/tb_dat_mem_lfsr5_unit.sv
// tb/tb_dat_mem_lfsr5_unit.sv - self-checking bench for dat_mem_lfsr5_unit
// Vector table, hand sequences and randomized run against an arithmetic reference model.
module tb_dat_mem_lfsr5_unit;

  logic       clk = 1'b0;
  logic       init;
  logic       write_en;
  logic [7:0] waddr;
  logic [7:0] raddr;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       lfsr_en;
  logic       lfsr_load;
  logic [4:0] taps;
  logic [4:0] start;
  logic [4:0] state;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mem_model [0:255];
  logic [4:0] st_model;

  dat_mem_lfsr5_unit dut (
    .clk(clk), .init(init), .write_en(write_en), .waddr(waddr), .raddr(raddr),
    .data_in(data_in), .data_out(data_out), .lfsr_en(lfsr_en), .lfsr_load(lfsr_load),
    .taps(taps), .start(start), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       init;
    logic       load;
    logic       en;
    logic [4:0] taps;
    logic [4:0] start;
    logic [4:0] exp_state;
  } lfsr_vec_t;

  lfsr_vec_t vecs [10];

  // Keystream step as arithmetic: shift left by one, new LSB is tap-masked parity.
  function automatic logic [4:0] lfsr_next(input logic [4:0] s, input logic [4:0] t);
    int v;
    v = ((int'(s) * 2) % 32) + ($countones(s & t) % 2);
    return v[4:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    init = 1'b0; write_en = 1'b0; lfsr_en = 1'b0; lfsr_load = 1'b0;
    waddr = 8'h00; data_in = 8'h00;
  endtask

  // Advance one edge and land 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_write(input logic [7:0] a, input logic [7:0] d);
    write_en = 1'b1; waddr = a; data_in = d;
    tick();
    mem_model[a] = d;
    write_en = 1'b0;
  endtask

  logic [4:0] tap_set [6];
  logic [4:0] key;
  logic [7:0] exp_rd;
  bit         early;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 5'h00, 5'h00, 5'h01};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 5'h1E, 5'h01, 5'h01};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 5'h1E, 5'h00, 5'h02};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 5'h1E, 5'h00, 5'h05};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 5'h1E, 5'h00, 5'h0B};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 5'h1E, 5'h0A, 5'h0A};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 5'h1E, 5'h0A, 5'h01};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 5'h1E, 5'h0A, 5'h01};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 5'h1E, 5'h00, 5'h00};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 5'h1E, 5'h00, 5'h00};
    tap_set[0] = 5'h12; tap_set[1] = 5'h1E; tap_set[2] = 5'h1D;
    tap_set[3] = 5'h1B; tap_set[4] = 5'h17; tap_set[5] = 5'h14;

    idle_inputs();
    raddr = 8'h00; taps = 5'h00; start = 5'h00;

    // Table-driven LFSR vectors (reset, step sequence, priority, lock-up).
    for (int i = 0; i < 10; i++) begin
      init = vecs[i].init; lfsr_load = vecs[i].load; lfsr_en = vecs[i].en;
      taps = vecs[i].taps; start = vecs[i].start;
      tick();
      check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].exp_state));
    end
    idle_inputs();

    // Period: exactly 31 steps back to 1F for every maximal tap set.
    for (int t = 0; t < 6; t++) begin
      taps = tap_set[t]; start = 5'h1F; lfsr_load = 1'b1;
      tick();
      lfsr_load = 1'b0; lfsr_en = 1'b1;
      st_model = 5'h1F;
      early = 1'b0;
      for (int s = 1; s <= 31; s++) begin
        tick();
        st_model = lfsr_next(st_model, taps);
        check($sformatf("period_t%0h_s%0d", taps, s), 32'(state), 32'(st_model));
        if (s < 31 && state == 5'h1F) early = 1'b1;
      end
      check($sformatf("period_t%0h_early", taps), 32'(early), 32'd0);
      check($sformatf("period_t%0h_ret", taps), 32'(state), 32'h1F);
      lfsr_en = 1'b0;
    end

    // Fill whole memory so every later read is defined.
    for (int a = 0; a < 256; a++) mem_write(8'(a), 8'($urandom));

    // Memory basics, persistence across init, write concurrent with init.
    mem_write(8'd192, 8'h7E);
    mem_write(8'd193, 8'h41);
    raddr = 8'd192; #1;
    check("mem_rd192", 32'(data_out), 32'h7E);
    raddr = 8'd193; #1;
    check("mem_rd193", 32'(data_out), 32'h41);
    init = 1'b1; write_en = 1'b1; waddr = 8'd194; data_in = 8'h55;
    tick();
    mem_model[194] = 8'h55;
    idle_inputs();
    raddr = 8'd192; #1;
    check("mem_after_init", 32'(data_out), 32'h7E);
    check("state_after_init", 32'(state), 32'h01);
    raddr = 8'd194; #1;
    check("mem_write_with_init", 32'(data_out), 32'h55);

    // Same-address read during write.
    mem_write(8'd5, 8'h33);
    raddr = 8'd5; write_en = 1'b1; waddr = 8'd5; data_in = 8'hC4; #1;
`ifdef MEM_WRITE_BYPASS_EN
    check("same_addr_pre", 32'(data_out), 32'hC4);
`else
    check("same_addr_pre", 32'(data_out), 32'h33);
`endif
    tick();
    mem_model[5] = 8'hC4;
    write_en = 1'b0; #1;
    check("same_addr_post", 32'(data_out), 32'hC4);

    // Decrypt smoke: recover key from the known 7E preamble, then next byte.
    key = 5'h13;
    mem_write(8'd128, 8'h7E ^ {3'b000, key});
    raddr = 8'd128; #1;
    taps = 5'h1E; start = data_out[4:0] ^ 5'h1E; lfsr_load = 1'b1;
    tick();
    lfsr_load = 1'b0;
    check("dec_key", 32'(state), 32'(key));
    check("dec_byte0", 32'(data_out ^ {3'b000, state}), 32'h7E);
    st_model = lfsr_next(key, 5'h1E);
    mem_write(8'd129, 8'h7E ^ {3'b000, st_model});
    lfsr_en = 1'b1;
    tick();
    lfsr_en = 1'b0;
    raddr = 8'd129; #1;
    check("dec_byte1", 32'(data_out ^ {3'b000, state}), 32'h7E);

    // Randomized run against the reference model.
    st_model = state;
    for (int i = 0; i < 400; i++) begin
      init      = ($urandom_range(0, 15) == 0);
      lfsr_load = ($urandom_range(0, 7) == 0);
      lfsr_en   = 1'($urandom);
      taps      = 5'($urandom);
      start     = 5'($urandom);
      write_en  = 1'($urandom);
      waddr     = 8'($urandom_range(0, 15));
      raddr     = 8'($urandom_range(0, 15));
      data_in   = 8'($urandom);
      #1;
      exp_rd = mem_model[raddr];
`ifdef MEM_WRITE_BYPASS_EN
      if (write_en && raddr == waddr) exp_rd = data_in;
`endif
      check($sformatf("rnd%0d_rd", i), 32'(data_out), 32'(exp_rd));
      @(posedge clk);
      if (write_en) mem_model[waddr] = data_in;
      if (init) st_model = 5'h01;
      else if (lfsr_load) st_model = start;
      else if (lfsr_en) st_model = lfsr_next(st_model, taps);
      #1;
      check($sformatf("rnd%0d_state", i), 32'(state), 32'(st_model));
    end
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
